mem_packet_sequencer: RTL

MEM_PACKET_SEQUENCER -- requirements
Module: mem_packet_sequencer

---
 rtl/mem_packet_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_packet_sequencer.sv
// Packet sequencer between a host loader and a ring memory.
// Packets are loaded into an issue buffer in IDLE. A start pulse streams them to the ring
// round-robin over NUM_PE destinations. Result packets are then collected into a result
// buffer that can be read combinationally.
// Optional feature: define MEM_SEQ_TIMEOUT_EN to abort collection after 1024 quiet cycles.
module mem_packet_sequencer #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned PWIDTH = 47,
  parameter int unsigned NUM_PE = 3,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [PWIDTH-1:0] ld_data_i,
  input  logic              start_i,
  input  logic [CW-1:0]     exp_cnt_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PWIDTH-1:0] out_data_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PWIDTH-1:0] in_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {StIdle, StSend, StCollect, StDone} state_e;

  state_e            state_q;
  // dest/src are rewritten on issue, so only type+payload are stored
  logic [PWIDTH-9:0] issue_q  [DEPTH];
  logic [DWIDTH-1:0] result_q [DEPTH];
  logic [CW-1:0]     load_cnt_q, idx_q, exp_q, rcv_q, rcv_d;
  logic [3:0]        pe_q;
  logic              err_q, timeout_q;
  logic              ld_fire, out_fire, in_fire, is_result, res_wr, pkt_bad, run_go, last_xfer;
  logic              tmo_hit;
  logic              unused_bits;

  assign unused_bits = ^{ld_data_i[PWIDTH-1 -: 8], in_data_i[PWIDTH-1 -: 8],
                         in_data_i[PWIDTH-11:DWIDTH]};

  // Status and handshake outputs decode directly from registered state
  assign ld_ready_o  = rst_n && (state_q == StIdle) && (load_cnt_q < CW'(DEPTH));
  assign out_valid_o = (state_q == StSend);
  assign in_ready_o  = (state_q == StSend) || (state_q == StCollect);
  assign busy_o      = in_ready_o;
  assign done_o      = (state_q == StDone);
  assign err_o       = err_q;
  assign timeout_o   = timeout_q;
  assign out_data_o  = {pe_q, 4'hF, issue_q[idx_q[AW-1:0]]};
  assign rd_data_o   = result_q[rd_addr_i];

  // Handshake decode and next receive count
  always_comb begin
    ld_fire   = ld_valid_i && ld_ready_o;
    out_fire  = out_valid_o && out_ready_i;
    in_fire   = in_valid_i && in_ready_o;
    is_result = (in_data_i[PWIDTH-9 -: 2] == 2'b10);
    res_wr    = in_fire && is_result && (rcv_q < CW'(DEPTH));
    pkt_bad   = in_fire && !res_wr;
    rcv_d     = rcv_q + CW'(res_wr);
    run_go    = (state_q == StIdle) && start_i && (load_cnt_q != '0);
    last_xfer = out_fire && (idx_q == load_cnt_q - CW'(1));
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  logic [9:0] quiet_cnt_q;

  assign tmo_hit = (state_q == StCollect) && !res_wr && (quiet_cnt_q == 10'd1023);

  // Collect cycles since the last accepted result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quiet_cnt_q <= '0;
    end else if (run_go || res_wr) begin
      quiet_cnt_q <= '0;
    end else if (state_q == StCollect) begin
      quiet_cnt_q <= quiet_cnt_q + 10'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Sequencer FSM with its counters and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      load_cnt_q <= '0;
      idx_q      <= '0;
      pe_q       <= '0;
      exp_q      <= '0;
      rcv_q      <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (ld_fire) load_cnt_q <= load_cnt_q + CW'(1);
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            if (load_cnt_q != '0) begin
              exp_q   <= exp_cnt_i;
              rcv_q   <= '0;
              idx_q   <= '0;
              pe_q    <= '0;
              state_q <= StSend;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StSend: begin
          rcv_q <= rcv_d;
          if (pkt_bad) err_q <= 1'b1;
          if (out_fire) begin
            idx_q <= idx_q + CW'(1);
            pe_q  <= (pe_q == 4'(NUM_PE - 1)) ? 4'd0 : pe_q + 4'd1;
          end
          if (last_xfer) state_q <= (rcv_d == exp_q) ? StDone : StCollect;
        end
        StCollect: begin
          rcv_q <= rcv_d;
          if (pkt_bad) err_q <= 1'b1;
          if (rcv_d == exp_q) begin
            state_q <= StDone;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          load_cnt_q <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Issue buffer write port
  always_ff @(posedge clk) begin
    if (ld_fire) issue_q[load_cnt_q[AW-1:0]] <= ld_data_i[PWIDTH-9:0];
  end

  // Result buffer: cleared at the start of a run, then filled in arrival order
  always_ff @(posedge clk) begin
    if (run_go) begin
      for (int i = 0; i < int'(DEPTH); i++) result_q[i] <= '0;
    end else if (res_wr) begin
      result_q[rcv_q[AW-1:0]] <= in_data_i[DWIDTH-1:0];
    end
  end

endmodule
